spart_rx: RTL and testbench

SPART_RX -- requirements
Module: spart_rx

---
 rtl/spart_pkg.sv | 31 +++
 rtl/spart_rx_if.sv | 43 ++++
 rtl/spart_sync.sv | 42 ++++
 rtl/spart_rx.sv | 147 ++++++++++++++
 tb/tb_spart_rx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared definitions for the SPART receiver: receive FSM state
//                encoding, oversampling and frame-size constants, and the
//                sized counter compare values derived from them.
//  Revision    : 1.0  initial release
// ============================================================================
package spart_pkg;

    localparam int OVERSAMPLE = 16;   // baud_clk pulses per bit time
    localparam int MID_SAMPLE = 7;    // sample count at the 8th tick (bit centre)
    localparam int DATA_BITS  = 8;    // 8N1 framing

    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_BITS);

    // Sized compare values so counter comparisons carry matching widths.
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(MID_SAMPLE);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_if
//  Description : Bundle of the SPART receiver serial input, baud enable and
//                consumer-side status/data signals.
//                slave  : receiver side (baud_clk, rxd, rd_ack in;
//                         rx_data, rda, frame_err, overrun out)
//                master : consumer / stimulus side (mirror image)
//  Revision    : 1.0  initial release
// ============================================================================
interface spart_rx_if;
    import spart_pkg::*;

    logic                 baud_clk;   // 16x oversample enable, one clk wide
    logic                 rxd;        // asynchronous serial line, idles high
    logic                 rd_ack;     // consumer read strobe
    logic [DATA_BITS-1:0] rx_data;    // last received byte
    logic                 rda;        // receive data available
    logic                 frame_err;  // last byte had a low stop bit
    logic                 overrun;    // byte completed while rda was set

    modport slave (
        input  baud_clk,
        input  rxd,
        input  rd_ack,
        output rx_data,
        output rda,
        output frame_err,
        output overrun
    );

    modport master (
        output baud_clk,
        output rxd,
        output rd_ack,
        input  rx_data,
        input  rda,
        input  frame_err,
        input  overrun
    );

endinterface : spart_rx_if
`default_nettype wire

// File: rtl/spart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spart_sync
//  Description : Single-bit two-flop synchronizer with a parameterized reset
//                value.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                d    - asynchronous input
//                q    - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module spart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : spart_sync
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx
//  Description : 8N1 serial receiver with 16x oversampling. Detects the start
//                edge, confirms it at mid-bit, samples each data bit and the
//                stop bit at the bit centre, and presents the byte with
//                data-available, framing-error and overrun flags.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - spart_rx_if.slave (baud_clk, rxd, rd_ack in;
//                       rx_data, rda, frame_err, overrun out)
//  Revision    : 1.0  initial release
// ============================================================================
module spart_rx
    import spart_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    spart_rx_if.slave  bus
);

    logic rxd_s;

    spart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rxd),
        .q   (rxd_s)
    );

    rx_state_e            state_q,      state_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rda_q,        rda_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
    // Set once the line has been seen high in IDLE. After a frame with a low
    // stop bit the line may still be low; this stops that level from being
    // mistaken for the next start bit.
    logic                 armed_q,      armed_d;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rda_d        = rda_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        armed_d      = armed_q;

        if (bus.baud_clk) begin
            sample_cnt_d = sample_cnt_q + 1'b1;   // natural 15 -> 0 wrap
        end

        // Consumer read clears the status; a completing frame below overrides.
        if (bus.rd_ack) begin
            rda_d       = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (rxd_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    sample_cnt_d = '0;
                    state_d      = START;
                end
            end

            START: begin
                if (bus.baud_clk && (sample_cnt_q == SAMPLE_MID)) begin
                    if (!rxd_s) begin
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        state_d      = DATA;
                    end else begin
                        state_d = IDLE;           // glitch, not a start bit
                    end
                end
            end

            DATA: begin
                if (bus.baud_clk && (sample_cnt_q == SAMPLE_LAST)) begin
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};  // LSB first
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (bus.baud_clk && (sample_cnt_q == SAMPLE_LAST)) begin
                    rx_data_d   = shift_q;
                    rda_d       = 1'b1;
                    frame_err_d = ~rxd_s;
                    overrun_d   = rda_q & ~bus.rd_ack;
                    armed_d     = rxd_s;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rda_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rda_q        <= rda_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            armed_q      <= armed_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rda       = rda_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule : spart_rx
`default_nettype wire

// File: tb/tb_spart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_rx
//  Description : Self-checking bench for spart_rx. baud_clk pulses every 4 clk
//                (bit time 64 clk). Directed vector table, hand-written corner
//                sequences and random frames checked against a frame-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spart_rx;

    logic clk = 1'b0;
    logic rst;

    spart_rx_if bus ();

    spart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Posedge counter; baud_clk is high for every posedge whose index is a
    // multiple of 4, so completion edges can be predicted exactly.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.baud_clk = 1'b0;
        forever begin
            @(negedge clk);
            bus.baud_clk = ((cyc + 1) % 4 == 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: receiver-visible state at frame level.
    logic [7:0] m_data;
    bit         m_rda, m_fe, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vs_model(input string tag);
        check({tag, ".rx_data"},   bus.rx_data,   m_data);
        check({tag, ".rda"},       bus.rda,       m_rda);
        check({tag, ".frame_err"}, bus.frame_err, m_fe);
        check({tag, ".overrun"},   bus.overrun,   m_ovr);
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic pulse_ack(input string tag);
        @(negedge clk);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
        check_vs_model({tag, ".ack"});
    endtask

    task automatic idle_gap(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame (640 clk). Optionally pulses rd_ack on the clk of
    // completion, asserts rst for 2 clk at offset rst_at, and checks that rda
    // rises exactly one clk after the mid-stop sampling edge.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit ack_done,
                              input int rst_at, input bit chk_lat);
        bit [9:0] frame;
        int c, f, p;
        frame = {stop, d, 1'b0};
        @(negedge clk);
        c = cyc;
        // rxd_s low after 2 posedges, FSM leaves IDLE on posedge c+3; then
        // 8 ticks to mid-start, 8*16 data ticks, 16 ticks to mid-stop.
        f = ((c + 3) / 4 + 1) * 4;
        p = f + 151 * 4;
        for (int k = 0; k < 640; k++) begin
            if (k > 0) @(negedge clk);
            bus.rxd    = frame[k / 64];
            bus.rd_ack = ack_done && (cyc == p - 1);
            if (rst_at >= 0) rst = (k >= rst_at) && (k < rst_at + 2);
            if (chk_lat && (cyc == p - 1)) check("latency.before", bus.rda, 1'b0);
            if (chk_lat && (cyc == p))     check("latency.after",  bus.rda, 1'b1);
        end
        bus.rd_ack = 1'b0;
        rst        = 1'b0;
        if (rst_at >= 0) begin
            model_reset();
        end else begin
            m_ovr  = ack_done ? 1'b0 : m_rda;
            m_rda  = 1'b1;
            m_fe   = ~stop;
            m_data = d;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         ack_before;
        logic [7:0] exp_data;
        bit         exp_rda;
        bit         exp_fe;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h5E, 1'b0, 1'b0, 8'h5E, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        rst        = 1'b1;
        bus.rxd    = 1'b1;
        bus.rd_ack = 1'b0;
        model_reset();

        // Reset values
        repeat (4) @(negedge clk);
        check_vs_model("reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].ack_before) pulse_ack($sformatf("vec%0d", i));
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, -1, !m_rda);
            idle_gap(vecs[i].stop ? 8 : 64);
            check($sformatf("vec%0d.rx_data", i),   bus.rx_data,   vecs[i].exp_data);
            check($sformatf("vec%0d.rda", i),       bus.rda,       vecs[i].exp_rda);
            check($sformatf("vec%0d.frame_err", i), bus.frame_err, vecs[i].exp_fe);
            check($sformatf("vec%0d.overrun", i),   bus.overrun,   vecs[i].exp_ovr);
        end

        // Short low pulse (3 baud ticks) is rejected as a false start
        pulse_ack("glitch");
        @(negedge clk);
        bus.rxd = 1'b0;
        repeat (12) @(negedge clk);
        idle_gap(700);
        check_vs_model("glitch");
        send_frame(8'hC3, 1'b1, 1'b0, -1, 1'b1);
        idle_gap(8);
        check_vs_model("after_glitch");

        // rd_ack on the completion clk while rda=1 and overrun=1
        send_frame(8'h33, 1'b1, 1'b0, -1, 1'b0);
        idle_gap(4);
        check_vs_model("pre_collide");
        send_frame(8'h7E, 1'b1, 1'b1, -1, 1'b0);
        idle_gap(8);
        check("collide.rx_data",   bus.rx_data,   8'h7E);
        check("collide.rda",       bus.rda,       1'b1);
        check("collide.frame_err", bus.frame_err, 1'b0);
        check("collide.overrun",   bus.overrun,   1'b0);

        // Reset during data bit 4 of 8'hFF, then a clean frame
        send_frame(8'hFF, 1'b1, 1'b0, 5 * 64 + 32, 1'b0);
        idle_gap(64);
        check_vs_model("mid_reset");
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1);
        idle_gap(8);
        check("rst_then.rx_data",   bus.rx_data,   8'h5A);
        check("rst_then.rda",       bus.rda,       1'b1);
        check("rst_then.frame_err", bus.frame_err, 1'b0);
        check("rst_then.overrun",   bus.overrun,   1'b0);

        // Random frames against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         stop, ackb, ackd;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            ackb = $urandom_range(0, 1) != 0;
            ackd = ($urandom_range(0, 4) == 0);
            if (ackb) pulse_ack($sformatf("rnd%0d", n));
            send_frame(d, stop, ackd, -1, !m_rda);
            if (stop) idle_gap($urandom_range(0, 20));
            else      idle_gap(64);
            check_vs_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_spart_rx
`default_nettype wire
